sc_ulpi_rac: RTL and testbench



---
 rtl/sc_ulpi_pkg.sv | 26 ++
 rtl/sc_ulpi_rac_rrarb.sv | 28 ++
 rtl/sc_ulpi_rac.sv | 187 ++++++++++++++++++
 tb/tb_sc_ulpi_rac.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_ulpi_pkg.sv
// Shared ULPI register-access definitions: command codes, extended-address
// escape, access result codes and RAC controller state encodings.
package sc_ulpi_pkg;

  localparam logic [1:0] ccdRegWrite  = 2'b10;
  localparam logic [1:0] ccdRegRead   = 2'b11;
  localparam logic [5:0] ULPI_EXT_ESC = 6'h2F;

  typedef enum logic [1:0] {
    racOk         = 2'd0,
    racVerifyFail = 2'd1,
    racTimeout    = 2'd2
  } racStatus_e;

  typedef logic [1:0] racState_e;
  localparam racState_e RAC_IDLE  = 2'd0;
  localparam racState_e RAC_ISSUE = 2'd1;
  localparam racState_e RAC_WAIT  = 2'd2;
  localparam racState_e RAC_VRD   = 2'd3;

  // 0x2F itself is the escape code, so it can only be reached via the extended form
  function automatic logic ulpi_is_ext(input logic [7:0] addr);
    return (addr[7:6] != 2'b00) || (addr == 8'h2F);
  endfunction

endpackage

// File: rtl/sc_ulpi_rac_rrarb.sv
// Round-robin arbiter: one-hot grant to the first requester after the
// last-granted index (ptr), wrapping around the vector.
module sc_ulpi_rac_rrarb #(
  parameter int NUM_CH = 2,
  parameter int PW     = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_vld
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_ulpi_rac.sv
// Multi-channel ULPI register access controller with extended addressing,
// write-verify retry and optional REG_ACK timeout (SC_ULPI_RAC_TIMEOUT_EN).
module sc_ulpi_rac
  import sc_ulpi_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int VERIFY_RETRY = 2,
  parameter int TIMEOUT_W    = 8
) (
  input  logic                ULPICLK,
  input  logic                ULPIRSTB,
  input  logic [NUM_CH-1:0]   CH_REQ,
  output logic [NUM_CH-1:0]   CH_ACK,
  input  logic [NUM_CH-1:0]   CH_WR0RD1,
  input  logic [NUM_CH-1:0]   CH_VERIFY,
  input  logic [8*NUM_CH-1:0] CH_ADDR,
  input  logic [8*NUM_CH-1:0] CH_WRDATA,
  output logic [7:0]          CH_RDDATA,
  output logic [1:0]          CH_STATUS,
  output logic                REG_REQ,
  input  logic                REG_ACK,
  output logic [1:0]          REG_CCD,
  output logic [5:0]          REG_CPD,
  output logic [7:0]          REG_EXT_ADDR,
  output logic [7:0]          REG_TX_DATA,
  input  logic [7:0]          ULPI_DATA
);

  localparam int         PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] RETRY_MAX = 3'(VERIFY_RETRY);

  if (NUM_CH < 1 || NUM_CH > 8 || VERIFY_RETRY < 0 || VERIFY_RETRY > 7 || TIMEOUT_W < 2)
  begin : g_param_chk
    $error("sc_ulpi_rac: parameter out of range");
  end

  racState_e        state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_ch;
  logic [PW-1:0]    arb_idx;
  logic [NUM_CH-1:0] arb_gnt;
  logic             arb_vld;
  logic             cap_rd;
  logic             cap_vfy;
  logic [7:0]       cap_addr;
  logic [7:0]       cap_wrdata;
  logic             rd_phase;
  logic [2:0]       retry_cnt;
  logic             fin;
  racStatus_e       fin_st;
  logic             vfy_mis;
  logic             addr_ext;
`ifdef SC_ULPI_RAC_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] tmo_cnt;
`endif

  sc_ulpi_rac_rrarb #(.NUM_CH(NUM_CH), .PW(PW)) u_rrarb (
    .req     (CH_REQ & ~CH_ACK),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  assign vfy_mis  = (ULPI_DATA != cap_wrdata);
  assign addr_ext = ulpi_is_ext(cap_addr);

  // Access completion: REG_ACK wins over a coincident timeout terminal count
  always_comb begin
    fin    = 1'b0;
    fin_st = racOk;
    if (state == RAC_WAIT) begin
      if (REG_ACK) begin
        if (!rd_phase) begin
          fin = !cap_vfy;
        end else if (cap_rd || !vfy_mis) begin
          fin = 1'b1;
        end else if (retry_cnt == RETRY_MAX) begin
          fin    = 1'b1;
          fin_st = racVerifyFail;
        end
      end
`ifdef SC_ULPI_RAC_TIMEOUT_EN
      else if (tmo_cnt == TMO_LAST) begin
        fin    = 1'b1;
        fin_st = racTimeout;
      end
`endif
    end
  end

  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB) begin
      state        <= RAC_IDLE;
      rr_ptr       <= '0;
      gnt_ch       <= '0;
      cap_rd       <= 1'b0;
      cap_vfy      <= 1'b0;
      cap_addr     <= '0;
      cap_wrdata   <= '0;
      rd_phase     <= 1'b0;
      retry_cnt    <= '0;
      CH_ACK       <= '0;
      CH_RDDATA    <= '0;
      CH_STATUS    <= '0;
      REG_REQ      <= 1'b0;
      REG_CCD      <= '0;
      REG_CPD      <= '0;
      REG_EXT_ADDR <= '0;
      REG_TX_DATA  <= '0;
`ifdef SC_ULPI_RAC_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      CH_ACK <= '0;
      case (state)
        RAC_IDLE: begin
          if (arb_vld) begin
            gnt_ch     <= arb_idx;
            rr_ptr     <= arb_idx;
            cap_rd     <= CH_WR0RD1[arb_idx];
            cap_vfy    <= CH_VERIFY[arb_idx];
            cap_addr   <= CH_ADDR[8*arb_idx +: 8];
            cap_wrdata <= CH_WRDATA[8*arb_idx +: 8];
            retry_cnt  <= '0;
            state      <= RAC_ISSUE;
          end
        end
        RAC_ISSUE: begin
          REG_CCD      <= cap_rd ? ccdRegRead : ccdRegWrite;
          REG_CPD      <= addr_ext ? ULPI_EXT_ESC : cap_addr[5:0];
          REG_EXT_ADDR <= addr_ext ? cap_addr : 8'h00;
          REG_TX_DATA  <= cap_wrdata;
          REG_REQ      <= 1'b1;
          rd_phase     <= cap_rd;
`ifdef SC_ULPI_RAC_TIMEOUT_EN
          tmo_cnt      <= '0;
`endif
          state        <= RAC_WAIT;
        end
        RAC_VRD: begin
          REG_CCD  <= ccdRegRead;
          REG_REQ  <= 1'b1;
          rd_phase <= 1'b1;
`ifdef SC_ULPI_RAC_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
          state    <= RAC_WAIT;
        end
        default: begin
          if (REG_ACK) begin
            REG_REQ <= 1'b0;
            if (rd_phase) CH_RDDATA <= ULPI_DATA;
            if (!fin) begin
              if (!rd_phase) begin
                state <= RAC_VRD;
              end else begin
                retry_cnt <= retry_cnt + 3'd1;
                state     <= RAC_ISSUE;
              end
            end
          end
`ifdef SC_ULPI_RAC_TIMEOUT_EN
          else if (fin) begin
            REG_REQ <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
      endcase
      if (fin) begin
        CH_ACK[gnt_ch] <= 1'b1;
        CH_STATUS      <= fin_st;
        state          <= RAC_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sc_ulpi_rac.sv
// Scoreboard bench for sc_ulpi_rac: PHY-side responder checks issued commands,
// completion monitor checks CH_ACK/CH_STATUS/CH_RDDATA against queued results.
module tb_sc_ulpi_rac;

  localparam int NUM_CH = 2;

  logic                ULPICLK = 1'b0;
  logic                ULPIRSTB;
  logic [NUM_CH-1:0]   CH_REQ;
  logic [NUM_CH-1:0]   CH_ACK;
  logic [NUM_CH-1:0]   CH_WR0RD1;
  logic [NUM_CH-1:0]   CH_VERIFY;
  logic [8*NUM_CH-1:0] CH_ADDR;
  logic [8*NUM_CH-1:0] CH_WRDATA;
  logic [7:0]          CH_RDDATA;
  logic [1:0]          CH_STATUS;
  logic                REG_REQ;
  logic                REG_ACK;
  logic [1:0]          REG_CCD;
  logic [5:0]          REG_CPD;
  logic [7:0]          REG_EXT_ADDR;
  logic [7:0]          REG_TX_DATA;
  logic [7:0]          ULPI_DATA;

  sc_ulpi_rac #(.NUM_CH(NUM_CH), .VERIFY_RETRY(2), .TIMEOUT_W(4)) dut (
    .ULPICLK(ULPICLK), .ULPIRSTB(ULPIRSTB),
    .CH_REQ(CH_REQ), .CH_ACK(CH_ACK), .CH_WR0RD1(CH_WR0RD1), .CH_VERIFY(CH_VERIFY),
    .CH_ADDR(CH_ADDR), .CH_WRDATA(CH_WRDATA), .CH_RDDATA(CH_RDDATA), .CH_STATUS(CH_STATUS),
    .REG_REQ(REG_REQ), .REG_ACK(REG_ACK), .REG_CCD(REG_CCD), .REG_CPD(REG_CPD),
    .REG_EXT_ADDR(REG_EXT_ADDR), .REG_TX_DATA(REG_TX_DATA), .ULPI_DATA(ULPI_DATA)
  );

  always #8 ULPICLK = ~ULPICLK;

  typedef struct {
    logic [1:0] ccd;
    logic [5:0] cpd;
    logic [7:0] ext;
    logic [7:0] tx;
  } cmd_t;

  typedef struct {
    int         ch;
    logic [1:0] st;
    logic [7:0] rd;
  } exp_t;

  cmd_t       cmd_q[$];
  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  int         total = 0;
  int         bad = 0;
  bit         phy_en;
  int         ack_delay;
  logic [7:0] mdl_rd;
  int         mdl_last;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic rd, input logic [7:0] addr, input logic [7:0] tx);
    cmd_t c;
    logic ext;
    ext   = (addr >= 8'h40) || (addr == 8'h2F);
    c.ccd = rd ? 2'b11 : 2'b10;
    c.cpd = ext ? 6'h2F : addr[5:0];
    c.ext = ext ? addr : 8'h00;
    c.tx  = tx;
    return c;
  endfunction

  function automatic exp_t mk_exp(input int ch, input logic [1:0] st, input logic [7:0] rd);
    exp_t e;
    e.ch = ch;
    e.st = st;
    e.rd = rd;
    return e;
  endfunction

  // PHY / link-controller side: check the command, then ACK after ack_delay cycles
  initial begin
    cmd_t c;
    forever begin
      @(negedge ULPICLK);
      if (phy_en && ULPIRSTB && REG_REQ && !REG_ACK) begin
        chk("cmdq_nonempty", 32'(cmd_q.size() != 0), 32'd1);
        if (cmd_q.size() != 0) begin
          c = cmd_q.pop_front();
          chk("reg_ccd", 32'(REG_CCD), 32'(c.ccd));
          chk("reg_cpd", 32'(REG_CPD), 32'(c.cpd));
          chk("reg_ext", 32'(REG_EXT_ADDR), 32'(c.ext));
          if (c.ccd == 2'b10) chk("reg_tx", 32'(REG_TX_DATA), 32'(c.tx));
        end
        repeat (ack_delay) @(negedge ULPICLK);
        ULPI_DATA = 8'hEE;
        if (REG_CCD == 2'b11 && rd_q.size() != 0) ULPI_DATA = rd_q.pop_front();
        REG_ACK = 1'b1;
        @(negedge ULPICLK);
        REG_ACK   = 1'b0;
        ULPI_DATA = 8'h00;
      end
    end
  end

  // Completion monitor
  initial begin
    logic [NUM_CH-1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge ULPICLK);
      if (CH_ACK != '0) begin
        chk("ack_single", 32'(CH_ACK & prev), 32'd0);
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'(CH_ACK), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_ch", 32'(CH_ACK), 32'(1 << e.ch));
          chk("status", 32'(CH_STATUS), 32'(e.st));
          chk("rddata", 32'(CH_RDDATA), 32'(e.rd));
        end
      end
      prev = CH_ACK;
    end
  end

  task automatic do_req(input int ch, input logic rd, input logic vfy, input logic [7:0] addr,
                        input logic [7:0] wd, output int lat);
    int n;
    bit got;
    CH_WR0RD1[ch]       = rd;
    CH_VERIFY[ch]       = vfy;
    CH_ADDR[8*ch +: 8]  = addr;
    CH_WRDATA[8*ch +: 8] = wd;
    CH_REQ[ch]          = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge ULPICLK);
      n++;
      got = CH_ACK[ch];
    end
    CH_REQ[ch] = 1'b0;
    chk("req_done", 32'(got), 32'd1);
    lat = n;
  endtask

  task automatic ch_loop(input int ch, input logic [7:0] addr);
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_req(ch, 1'b1, 1'b0, addr, 8'h00, lat);
      @(negedge ULPICLK);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  f;
    int  cnt;
    int  n;
    bit  got;
    ULPIRSTB  = 1'b0;
    CH_REQ    = '0;
    CH_WR0RD1 = '0;
    CH_VERIFY = '0;
    CH_ADDR   = '0;
    CH_WRDATA = '0;
    REG_ACK   = 1'b0;
    ULPI_DATA = 8'h00;
    phy_en    = 1'b1;
    ack_delay = 2;
    mdl_rd    = 8'h00;
    mdl_last  = 0;

    repeat (3) @(negedge ULPICLK);
    chk("reset_outputs", 32'({CH_ACK, CH_RDDATA, CH_STATUS, REG_REQ, REG_CCD, REG_CPD,
                              REG_EXT_ADDR, REG_TX_DATA}), 32'd0);
    ULPIRSTB = 1'b1;
    @(negedge ULPICLK);

    // ch0 plain write, ACK two cycles into WAIT
    cmd_q.push_back(mk_cmd(1'b0, 8'h0A, 8'h06));
    exp_q.push_back(mk_exp(0, 2'd0, mdl_rd));
    do_req(0, 1'b0, 1'b0, 8'h0A, 8'h06, lat);
    mdl_last = 0;
    @(negedge ULPICLK);

    // ch1 reads through the extended-address escape
    rd_q.push_back(8'h5A);
    cmd_q.push_back(mk_cmd(1'b1, 8'h85, 8'h00));
    exp_q.push_back(mk_exp(1, 2'd0, 8'h5A));
    do_req(1, 1'b1, 1'b0, 8'h85, 8'h00, lat);
    mdl_rd = 8'h5A;
    @(negedge ULPICLK);
    rd_q.push_back(8'hA5);
    cmd_q.push_back(mk_cmd(1'b1, 8'h2F, 8'h00));
    exp_q.push_back(mk_exp(1, 2'd0, 8'hA5));
    do_req(1, 1'b1, 1'b0, 8'h2F, 8'h00, lat);
    mdl_rd   = 8'hA5;
    mdl_last = 1;
    @(negedge ULPICLK);

    // Minimum access latency with REG_ACK in the first WAIT cycle
    ack_delay = 0;
    rd_q.push_back(8'h3C);
    cmd_q.push_back(mk_cmd(1'b1, 8'h07, 8'h00));
    exp_q.push_back(mk_exp(0, 2'd0, 8'h3C));
    do_req(0, 1'b1, 1'b0, 8'h07, 8'h00, lat);
    chk("min_latency", 32'(lat), 32'd3);
    mdl_rd   = 8'h3C;
    mdl_last = 0;
    @(negedge ULPICLK);

    // Both channels requesting continuously: grants alternate
    ack_delay = 1;
    f = (mdl_last + 1) % NUM_CH;
    for (int k = 0; k < 6; k++) begin
      int ch;
      ch = (k % 2 == 0) ? f : 1 - f;
      rd_q.push_back(8'(8'h30 + k));
      cmd_q.push_back(mk_cmd(1'b1, (ch == 1) ? 8'h3C : 8'h15, 8'h00));
      exp_q.push_back(mk_exp(ch, 2'd0, 8'(8'h30 + k)));
    end
    fork
      ch_loop(0, 8'h15);
      ch_loop(1, 8'h3C);
    join
    mdl_rd   = 8'h35;
    mdl_last = 1 - f;
    chk("alt_cmd_drained", 32'(cmd_q.size()), 32'd0);

    // Write-verify: first read-back mismatches, second matches
    for (int k = 0; k < 2; k++) begin
      cmd_q.push_back(mk_cmd(1'b0, 8'h04, 8'h45));
      cmd_q.push_back(mk_cmd(1'b1, 8'h04, 8'h45));
    end
    rd_q.push_back(8'h41);
    rd_q.push_back(8'h45);
    exp_q.push_back(mk_exp(0, 2'd0, 8'h45));
    do_req(0, 1'b0, 1'b1, 8'h04, 8'h45, lat);
    chk("vfy_ok_cmds", 32'(cmd_q.size()), 32'd0);
    @(negedge ULPICLK);

    // Write-verify never matches: 1 + VERIFY_RETRY writes then verify fail
    for (int k = 0; k < 3; k++) begin
      cmd_q.push_back(mk_cmd(1'b0, 8'h04, 8'h45));
      cmd_q.push_back(mk_cmd(1'b1, 8'h04, 8'h45));
      rd_q.push_back(8'h41);
    end
    exp_q.push_back(mk_exp(0, 2'd1, 8'h41));
    do_req(0, 1'b0, 1'b1, 8'h04, 8'h45, lat);
    chk("vfy_fail_cmds", 32'(cmd_q.size()), 32'd0);
    mdl_rd   = 8'h41;
    mdl_last = 0;
    @(negedge ULPICLK);

    // REG_ACK withheld
    phy_en = 1'b0;
    CH_WR0RD1[1]     = 1'b0;
    CH_VERIFY[1]     = 1'b0;
    CH_ADDR[15:8]    = 8'h11;
    CH_WRDATA[15:8]  = 8'h22;
`ifdef SC_ULPI_RAC_TIMEOUT_EN
    exp_q.push_back(mk_exp(1, 2'd2, mdl_rd));
    CH_REQ[1] = 1'b1;
    cnt = 0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge ULPICLK);
      n++;
      got = CH_ACK[1];
      if (REG_REQ) cnt++;
    end
    CH_REQ[1] = 1'b0;
    chk("tmo_done", 32'(got), 32'd1);
    chk("tmo_cycles", 32'(cnt), 32'd15);
`else
    exp_q.push_back(mk_exp(1, 2'd0, mdl_rd));
    CH_REQ[1] = 1'b1;
    @(negedge ULPICLK);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge ULPICLK);
      if (REG_REQ) cnt++;
    end
    chk("wait_hold", 32'(cnt), 32'd40);
    cmd_q.push_back(mk_cmd(1'b0, 8'h11, 8'h22));
    ack_delay = 0;
    phy_en    = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge ULPICLK);
      n++;
      got = CH_ACK[1];
    end
    CH_REQ[1] = 1'b0;
    chk("late_ack", 32'(got), 32'd1);
    phy_en = 1'b0;
`endif
    @(negedge ULPICLK);

    // Reset in the middle of WAIT
    CH_WR0RD1[0]    = 1'b0;
    CH_VERIFY[0]    = 1'b0;
    CH_ADDR[7:0]    = 8'h33;
    CH_WRDATA[7:0]  = 8'h77;
    CH_REQ[0]       = 1'b1;
    repeat (4) @(negedge ULPICLK);
    chk("pre_rst_req", 32'(REG_REQ), 32'd1);
    ULPIRSTB = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({CH_ACK, CH_RDDATA, CH_STATUS, REG_REQ, REG_CCD, REG_CPD,
                                REG_EXT_ADDR, REG_TX_DATA}), 32'd0);
    CH_REQ = '0;
    repeat (2) @(negedge ULPICLK);
    ULPIRSTB = 1'b1;
    repeat (10) @(negedge ULPICLK);
    chk("post_rst_req", 32'(REG_REQ), 32'd0);
    chk("expq_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
